// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and default sizing.
// Imported by the CDB arbiter and its source FIFOs.
package cdb_arbiter_pkg;

  localparam int XLEN    = 32;
  localparam int ROB_IDW = 6;

  typedef logic [XLEN-1:0]    word_t;
  typedef logic [ROB_IDW-1:0] rob_id_t;

  typedef struct packed {
    rob_id_t    rob_id;
    word_t      w_data;
    logic       r_valid;
    logic       exc_valid;
    logic [3:0] exc_code;
  } cdb_info_t;

  localparam int DEF_SRC_COUNT  = 4;
  localparam int DEF_CDB_COUNT  = 2;
  localparam int DEF_FIFO_DEPTH = 2;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO in front of the CDB.
// Full FIFO ignores push; flush overrides push and pop.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push_i,
  input  cdb_info_t data_i,
  input  logic      pop_i,
  output cdb_info_t head_o,
  output logic      empty_o,
  output logic      full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  cdb_info_t mem [DEPTH];
  ptr_t      rd;
  ptr_t      wr;
  cnt_t      cnt;
  logic      do_push;
  logic      do_pop;

  assign do_push = push_i & ~full_o & ~flush;
  assign do_pop  = pop_i & ~empty_o & ~flush;
  assign head_o  = mem[rd];
  assign empty_o = (cnt == '0);
  assign full_o  = (cnt == cnt_t'(DEPTH));

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else if (flush) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + ptr_t'(1);
      if (do_pop)  rd <= rd + ptr_t'(1);
      if (do_push && !do_pop) cnt <= cnt + cnt_t'(1);
      else if (do_pop && !do_push) cnt <= cnt - cnt_t'(1);
    end
  end

  // Payload storage needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= data_i;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Buffers execution-unit results and broadcasts
// up to CDB_COUNT of them per cycle, round-robin.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int SRC_COUNT  = DEF_SRC_COUNT,
  parameter int CDB_COUNT  = DEF_CDB_COUNT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [SRC_COUNT-1:0] src_valid_i,
  input  cdb_info_t            src_info_i [SRC_COUNT],
  output logic [SRC_COUNT-1:0] src_ready_o,
  output logic [CDB_COUNT-1:0] cdb_valid_o,
  output cdb_info_t            cdb_info_o [CDB_COUNT],
  output word_t                cdb_data_o [CDB_COUNT],
  output rob_id_t              cdb_reg_id_o [CDB_COUNT]
);

  localparam int PW = (SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1;

  typedef logic [PW-1:0] rr_t;

  rr_t                  rr_ptr;
  rr_t                  rr_nxt;
  logic [SRC_COUNT-1:0] empty;
  logic [SRC_COUNT-1:0] full;
  logic [SRC_COUNT-1:0] pop;
  cdb_info_t            head [SRC_COUNT];
  logic [CDB_COUNT-1:0] lane_vld;
  cdb_info_t            lane_info [CDB_COUNT];

  assign src_ready_o = ~full;

  for (genvar s = 0; s < SRC_COUNT; s++) begin : g_src
    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .push_i  (src_valid_i[s] & ~full[s]),
      .data_i  (src_info_i[s]),
      .pop_i   (pop[s]),
      .head_o  (head[s]),
      .empty_o (empty[s]),
      .full_o  (full[s])
    );
  end

  // Scan from rr_ptr, granting the first non-empty heads to lanes in order.
  always_comb begin
    int n;
    int idx;
    pop      = '0;
    lane_vld = '0;
    rr_nxt   = rr_ptr;
    n        = 0;
    idx      = 0;
    for (int k = 0; k < CDB_COUNT; k++) lane_info[k] = '0;
    for (int i = 0; i < SRC_COUNT; i++) begin
      idx = (int'(rr_ptr) + i) % SRC_COUNT;
      if (!empty[idx] && n < CDB_COUNT) begin
        pop[idx]     = 1'b1;
        lane_vld[n]  = 1'b1;
        lane_info[n] = head[idx];
        rr_nxt       = rr_t'((idx + 1) % SRC_COUNT);
        n++;
      end
    end
  end

  // Round-robin pointer and registered CDB lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      cdb_valid_o <= '0;
      cdb_info_o  <= '{default: '0};
    end else if (flush) begin
      rr_ptr      <= '0;
      cdb_valid_o <= '0;
      cdb_info_o  <= '{default: '0};
    end else begin
      rr_ptr      <= rr_nxt;
      cdb_valid_o <= lane_vld;
      cdb_info_o  <= lane_info;
    end
  end

  // Forwarding views of the broadcast results.
  always_comb begin
    for (int k = 0; k < CDB_COUNT; k++) begin
      cdb_data_o[k]   = cdb_info_o[k].w_data;
      cdb_reg_id_o[k] = cdb_info_o[k].rob_id;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios plus
// random traffic against a queue-based reference model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int S = 4;
  localparam int C = 2;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic [S-1:0] src_valid = '0;
  cdb_info_t    src_info [S];
  logic [S-1:0] src_ready;
  logic [C-1:0] cdb_valid;
  cdb_info_t    cdb_info [C];
  word_t        cdb_data [C];
  rob_id_t      cdb_reg_id [C];

  cdb_info_t    mq [S][$];
  int           rr_m;
  logic [C-1:0] exp_valid;
  cdb_info_t    exp_info [C];
  logic [S-1:0] exp_ready;
  logic [S-1:0] acc_m;
  logic [S-1:0] gr_m;
  int           seq [S];

  int n_cmp = 0;
  int n_bad = 0;

  cdb_arbiter #(
    .SRC_COUNT  (S),
    .CDB_COUNT  (C),
    .FIFO_DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .src_valid_i  (src_valid),
    .src_info_i   (src_info),
    .src_ready_o  (src_ready),
    .cdb_valid_o  (cdb_valid),
    .cdb_info_o   (cdb_info),
    .cdb_data_o   (cdb_data),
    .cdb_reg_id_o (cdb_reg_id)
  );

  always #5 clk = ~clk;

  function automatic cdb_info_t mk(int s);
    cdb_info_t r;
    logic [3:0] q;
    q           = 4'(seq[s]);
    seq[s]      = seq[s] + 1;
    r.rob_id    = {2'(s), q};
    r.w_data    = $urandom;
    r.r_valid   = 1'($urandom);
    r.exc_valid = 1'($urandom);
    r.exc_code  = 4'($urandom);
    return r;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < S; s++) mq[s].delete();
    rr_m = 0;
    exp_ready = '1;
  endtask

  // Predict the next CDB from the model, advance one edge, update model.
  task automatic tick();
    int nl;
    int last;
    nl = 0;
    last = -1;
    exp_valid = '0;
    gr_m = '0;
    acc_m = '0;
    for (int k = 0; k < C; k++) exp_info[k] = '0;
    for (int s = 0; s < S; s++)
      acc_m[s] = src_valid[s] && mq[s].size() < D && !flush;
    for (int i = 0; i < S; i++) begin
      int j;
      j = (rr_m + i) % S;
      if (mq[j].size() > 0 && nl < C) begin
        exp_valid[nl] = 1'b1;
        exp_info[nl] = mq[j][0];
        gr_m[j] = 1'b1;
        nl++;
        last = j;
      end
    end
    if (flush) exp_valid = '0;
    @(posedge clk);
    #1;
    if (flush) begin
      model_clear();
    end else begin
      for (int s = 0; s < S; s++) begin
        if (gr_m[s]) void'(mq[s].pop_front());
        if (acc_m[s]) mq[s].push_back(src_info[s]);
      end
      if (last >= 0) rr_m = (last + 1) % S;
    end
    for (int s = 0; s < S; s++) exp_ready[s] = mq[s].size() < D;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    src_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (cdb_valid !== 2'b00 || cdb_info[0] !== '0) begin
      n_bad++;
      $display("FAIL reset_out: valid=%b info0=%h want 00/0",
               cdb_valid, cdb_info[0]);
    end
    n_cmp++;
    if (src_ready !== 4'b1111) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 1111", src_ready);
    end
    rst_n = 1'b1;
    model_clear();
    for (int s = 0; s < S; s++) src_info[s] = mk(s);
    src_valid = 4'b1111;
    tick();
    tick();
    n_cmp++;
    if (cdb_valid !== exp_valid) begin
      n_bad++;
      $display("FAIL pre_reset_lanes: got %b want %b", cdb_valid, exp_valid);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (cdb_valid !== 2'b00) begin
      n_bad++;
      $display("FAIL async_reset: valid=%b want 00", cdb_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    src_valid = '0;
    model_clear();
    #1;
    n_cmp++;
    if (src_ready !== 4'b1111 || cdb_valid !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_release: ready=%b valid=%b want 1111/00",
               src_ready, cdb_valid);
    end
  endtask

  task automatic test_single();
    src_info[1] = '{rob_id: 6'd5, w_data: 32'hDEAD_BEEF,
                    r_valid: 1'b1, exc_valid: 1'b0, exc_code: 4'h0};
    src_valid = 4'b0010;
    tick();
    src_valid = '0;
    n_cmp++;
    if (cdb_valid !== 2'b00) begin
      n_bad++;
      $display("FAIL single_no_bypass: valid=%b want 00", cdb_valid);
    end
    tick();
    n_cmp++;
    if (cdb_valid !== 2'b01 || cdb_reg_id[0] !== 6'd5 ||
        cdb_data[0] !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL single_lane0: valid=%b id=%0d data=%h want 01/5/deadbeef",
               cdb_valid, cdb_reg_id[0], cdb_data[0]);
    end
    n_cmp++;
    if (dut.rr_ptr !== 2'(rr_m) || rr_m != 2) begin
      n_bad++;
      $display("FAIL single_rr: got %0d model %0d want 2", dut.rr_ptr, rr_m);
    end
  endtask

  task automatic test_contention();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int s = 0; s < S; s++) src_info[s] = mk(s);
    src_valid = 4'b1111;
    tick();
    src_valid = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int k = 0; k < C; k++) begin
        n_cmp++;
        if (cdb_valid[k] !== exp_valid[k] ||
            (exp_valid[k] && (cdb_info[k] !== exp_info[k] ||
             cdb_info[k].rob_id[5:4] !== 2'(2 * c + k)))) begin
          n_bad++;
          $display("FAIL contention c%0d lane%0d: v=%b info=%h want v=%b info=%h",
                   c, k, cdb_valid[k], cdb_info[k], exp_valid[k], exp_info[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit saw_full2;
    saw_full2 = 1'b0;
    for (int s = 0; s < S; s++) src_info[s] = mk(s);
    src_valid = 4'b1111;
    for (int c = 0; c < 24; c++) begin
      tick();
      for (int s = 0; s < S; s++)
        if (acc_m[s]) src_info[s] = mk(s);
      if (!src_ready[2]) saw_full2 = 1'b1;
      n_cmp++;
      if (src_ready !== exp_ready) begin
        n_bad++;
        $display("FAIL bp_ready c%0d: got %b want %b", c, src_ready, exp_ready);
      end
      for (int k = 0; k < C; k++) begin
        n_cmp++;
        if (cdb_valid[k] !== exp_valid[k] ||
            (exp_valid[k] && (cdb_info[k] !== exp_info[k] ||
             cdb_reg_id[k] !== exp_info[k].rob_id))) begin
          n_bad++;
          $display("FAIL bp_lane c%0d lane%0d: v=%b info=%h want v=%b info=%h",
                   c, k, cdb_valid[k], cdb_info[k], exp_valid[k], exp_info[k]);
        end
      end
    end
    n_cmp++;
    if (!saw_full2) begin
      n_bad++;
      $display("FAIL bp_src2_full: ready[2] stayed 1, want a 0");
    end
    src_valid = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (cdb_valid !== exp_valid ||
          (exp_valid[0] && cdb_info[0] !== exp_info[0])) begin
        n_bad++;
        $display("FAIL bp_drain c%0d: v=%b want %b", c, cdb_valid, exp_valid);
      end
    end
  endtask

  task automatic test_flush();
    cdb_info_t p0;
    for (int s = 1; s < S; s++) src_info[s] = mk(s);
    src_valid = 4'b1110;
    tick();
    p0 = mk(0);
    src_info[0] = p0;
    src_valid = 4'b0001;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    src_valid = '0;
    n_cmp++;
    if (cdb_valid !== 2'b00 || src_ready !== 4'b1111) begin
      n_bad++;
      $display("FAIL flush_state: valid=%b ready=%b want 00/1111",
               cdb_valid, src_ready);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (cdb_valid !== 2'b00 ||
          (cdb_valid[0] && cdb_reg_id[0] === p0.rob_id)) begin
        n_bad++;
        $display("FAIL flush_drop c%0d: valid=%b want 00", c, cdb_valid);
      end
    end
  endtask

  task automatic test_random();
    bit pend [S];
    int wt [S];
    int n_push;
    int n_bcast;
    n_push = 0;
    n_bcast = 0;
    for (int s = 0; s < S; s++) begin
      pend[s] = 1'b0;
      wt[s] = 0;
    end
    for (int c = 0; c < 10000 + 6; c++) begin
      for (int s = 0; s < S; s++) begin
        if (!pend[s] && c < 10000 && $urandom_range(0, 99) < 60) begin
          pend[s] = 1'b1;
          src_info[s] = mk(s);
        end
        src_valid[s] = pend[s];
        if (mq[s].size() > 0) wt[s]++;
      end
      tick();
      for (int s = 0; s < S; s++)
        if (acc_m[s]) begin
          pend[s] = 1'b0;
          n_push++;
        end
      n_cmp++;
      if (src_ready !== exp_ready) begin
        n_bad++;
        $display("FAIL rnd_ready c%0d: got %b want %b", c, src_ready, exp_ready);
      end
      for (int k = 0; k < C; k++) begin
        n_cmp++;
        if (cdb_valid[k] !== exp_valid[k] ||
            (exp_valid[k] && (cdb_info[k] !== exp_info[k] ||
             cdb_data[k] !== exp_info[k].w_data))) begin
          n_bad++;
          $display("FAIL rnd_lane c%0d lane%0d: v=%b info=%h want v=%b info=%h",
                   c, k, cdb_valid[k], cdb_info[k], exp_valid[k], exp_info[k]);
        end
        if (cdb_valid[k] === 1'b1) begin
          n_bcast++;
          wt[cdb_info[k].rob_id[5:4]] = 0;
        end
      end
      for (int s = 0; s < S; s++) begin
        n_cmp++;
        if (wt[s] >= (S + C - 1) / C) begin
          n_bad++;
          $display("FAIL rnd_starve c%0d src%0d: waited %0d want < %0d",
                   c, s, wt[s], (S + C - 1) / C);
          wt[s] = 0;
        end
      end
    end
    n_cmp++;
    if (n_bcast != n_push) begin
      n_bad++;
      $display("FAIL rnd_count: broadcast %0d want %0d", n_bcast, n_push);
    end
  endtask

  initial begin
    for (int s = 0; s < S; s++) begin
      seq[s] = 0;
      src_info[s] = '0;
    end
    model_clear();
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
